// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Fetch sequencer between the combinational instruction ROM and decode.
// It drives the program counter into the ROM and captures the returned
// instruction into a 2-entry prefetch FIFO. Decode takes the FIFO head over a
// valid/ready handshake. A redirect from downstream flushes the FIFO and
// restarts fetch at redirect_pc. Fetch stops once a halt opcode has been
// captured, and halted rises after decode accepts that halt.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   pc           out  fetch address to ROM
//   instruction  in   ROM data for pc, valid in the same cycle
//   out_valid    out  FIFO head valid
//   out_ready    in   decode accepts the head
//   out_inst     out  head instruction
//   out_pc       out  address of the head instruction
//   redirect     in   branch/jump taken: flush and refetch
//   redirect_pc  in   new fetch address
//   halted       out  halt instruction has been accepted by decode
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 9,
    parameter logic [PC_W-1:0] RESET_PC = 1,
    parameter logic [4:0]      HALT_OP  = 5'b11010
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              halted
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t     state, state_nxt;
    entry_t     head, tail, new_e;
    logic [1:0] count;
    logic       pop, fetch_en, is_halt;

    assign out_valid = (count != 2'd0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign halted    = (state == S_HALTED);

    assign pop      = out_valid & out_ready;
    // count - pop < 2: there is room now, or the head leaves this cycle.
    assign fetch_en = (state == S_FETCH) & ~redirect & ((count < 2'd2) | pop);
    assign new_e    = '{pc: pc, inst: instruction};
    assign is_halt  = (instruction[INST_W-1 -: 5] == HALT_OP);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (fetch_en && is_halt) state_nxt = S_DRAIN;
                // Nothing is pushed after the halt, so it is always the last
                // entry: popping with one entry left is popping the halt.
                S_DRAIN:  if (pop && count == 2'd1) state_nxt = S_HALTED;
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------ PC and FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect) begin
            // A coincident pop is simply absorbed by the flush.
            pc    <= redirect_pc;
            count <= 2'd0;
        end else begin
            if (fetch_en) pc <= pc + PC_W'(1);
            case (count)
                2'd0: begin
                    if (fetch_en) begin
                        head  <= new_e;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (fetch_en && pop) begin
                        head <= new_e;
                    end else if (fetch_en) begin
                        tail  <= new_e;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Push without pop cannot happen when full.
                    if (pop) begin
                        head <= tail;
                        if (fetch_en) tail  <= new_e;
                        else          count <= 2'd1;
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//
// Directed bench for inst_fetch_ctrl. A table of per-cycle vectors covers a
// straight run into a halt and a redirect out of halted. Hand-written
// sequences cover backpressure, redirect while full, PC wrap and an
// asynchronous reset that arrives in the middle of a run.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic [8:0]  instruction;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_inst;
    logic [15:0] out_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halted;
    logic        rom_halt_en = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM model: pc1 = 9'h061, pc >= 15 holds halt (when enabled),
    // everything else is 9'h05x with x = pc[3:0].
    function automatic logic [8:0] rom(input logic [15:0] a, input logic hen);
        if (hen && a >= 16'd15) return 9'h1A0;
        if (a == 16'd1)         return 9'h061;
        return {5'b00101, a[3:0]};
    endfunction

    assign instruction = rom(pc, rom_halt_en);

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        e_valid;
        logic [15:0] e_opc;
        logic [8:0]  e_inst;
        logic [15:0] e_pc;
        logic        e_halted;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rdy, input logic redir,
                                input logic [15:0] rpc, input logic ev,
                                input logic [15:0] eopc, input logic [8:0] einst,
                                input logic [15:0] epc, input logic eh);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.e_valid = ev;
        v.e_opc = eopc; v.e_inst = einst; v.e_pc = epc; v.e_halted = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_st(input string nm, input logic ev, input logic [15:0] eopc,
                             input logic [8:0] einst, input logic [15:0] epc,
                             input logic eh);
        chk({nm, " out_valid"}, 16'(out_valid), 16'(ev));
        chk({nm, " pc"},        pc,             epc);
        chk({nm, " halted"},    16'(halted),    16'(eh));
        if (ev) begin
            chk({nm, " out_pc"},   out_pc,         eopc);
            chk({nm, " out_inst"}, 16'(out_inst),  16'(einst));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, check reset values, release after an edge so
    // the next edge is the first fetch.
    task automatic do_reset();
        rst       = 1'b1;
        redirect  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset out_valid", 16'(out_valid), 16'd0);
        chk("reset pc",        pc,             16'd1);
        chk("reset out_pc",    out_pc,         16'd0);
        chk("reset out_inst",  16'(out_inst),  16'd0);
        chk("reset halted",    16'(halted),    16'd0);
        rst = 1'b0;
    endtask

    initial begin
        // ---- table: straight run into halt, then redirect out of halted
        for (int k = 1; k <= 14; k++)
            tbl.push_back(mk(1'b1, 1'b0, 16'd0, 1'b1, 16'(k), rom(16'(k), 1'b1), 16'(k + 1), 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'd0,  1'b1, 16'd15, 9'h1A0, 16'd16, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 16'd16, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 16'd16, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  9'h000, 16'd16, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, 16'd5,  1'b0, 16'd0,  9'h000, 16'd5,  1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'd0,  1'b1, 16'd5,  9'h055, 16'd6,  1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 16'd0,  1'b1, 16'd6,  9'h056, 16'd7,  1'b0));

        rom_halt_en = 1'b1;
        do_reset();
        foreach (tbl[i]) begin
            out_ready   = tbl[i].rdy;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            tick();
            expect_st($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_opc,
                      tbl[i].e_inst, tbl[i].e_pc, tbl[i].e_halted);
        end
        redirect = 1'b0;

        // ---- backpressure: fill in two cycles, pc holds at 3, head stable
        do_reset();
        out_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            expect_st($sformatf("bp hold%0d", c), 1'b1, 16'd1, 9'h061,
                      (c == 1) ? 16'd2 : 16'd3, 1'b0);
        end
        out_ready = 1'b1;
        tick(); expect_st("bp rel1", 1'b1, 16'd2, 9'h052, 16'd4, 1'b0);
        tick(); expect_st("bp rel2", 1'b1, 16'd3, 9'h053, 16'd5, 1'b0);
        tick(); expect_st("bp rel3", 1'b1, 16'd4, 9'h054, 16'd6, 1'b0);

        // ---- redirect while full, with a coincident pop
        do_reset();
        out_ready = 1'b0;
        tick();
        tick(); expect_st("full", 1'b1, 16'd1, 9'h061, 16'd3, 1'b0);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'd10;
        tick(); expect_st("redir flush", 1'b0, 16'd0, 9'h000, 16'd10, 1'b0);
        redirect = 1'b0;
        tick(); expect_st("redir first", 1'b1, 16'd10, 9'h05A, 16'd11, 1'b0);

        // ---- pc wrap, then asynchronous reset mid-stream
        rom_halt_en = 1'b0;
        do_reset();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick(); expect_st("wrap redir", 1'b0, 16'd0, 9'h000, 16'hFFFF, 1'b0);
        redirect = 1'b0;
        tick(); expect_st("wrap ffff", 1'b1, 16'hFFFF, 9'h05F, 16'h0000, 1'b0);
        tick(); expect_st("wrap 0000", 1'b1, 16'h0000, 9'h050, 16'h0001, 1'b0);
        tick(); expect_st("wrap 0001", 1'b1, 16'h0001, 9'h061, 16'h0002, 1'b0);
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 16'(out_valid), 16'd0);
        chk("async rst pc",        pc,             16'd1);
        chk("async rst out_pc",    out_pc,         16'd0);
        chk("async rst out_inst",  16'(out_inst),  16'd0);
        tick();
        rst = 1'b0;
        tick(); expect_st("post rst", 1'b1, 16'd1, 9'h061, 16'd2, 1'b0);
        tick(); expect_st("post rst2", 1'b1, 16'd2, 9'h052, 16'd3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer that drives the program counter into the combinational instruction ROM. It captures each 9-bit instruction into a 2-entry prefetch buffer and hands instructions to decode over a valid/ready handshake. Branch and jump redirects from downstream flush the buffer. When a `halt` opcode is fetched, fetching stops. The block sits between the instruction ROM and the decode stage of the pipelined CPU.

## Interface
- `PC_W`, 16, program counter width
- `INST_W`, 9, instruction width (5-bit opcode + 4-bit operand)
- `RESET_PC`, 1, first fetch address after reset
- `HALT_OP`, 5'b11010, opcode that stops fetching

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  out  PC_W  fetch address to ROM
- `instruction`  in  INST_W  ROM data for `pc`, valid in the same cycle
- `out_valid`  out  1  head of buffer valid
- `out_ready`  in  1  decode accepts head
- `out_inst`  out  INST_W  head instruction
- `out_pc`  out  PC_W  address of head instruction
- `redirect`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  PC_W  new fetch address
- `halted`  out  1  halt instruction has been accepted by decode

## Operation
- Buffer: 2-entry FIFO of {pc, instruction}.
  - `count` is 0..2.
  - `out_*` present the head entry.
  - `out_valid` = (count != 0).
- pop = out_valid & out_ready.
- fetch_en = !stop_fetch & !halted & !redirect & (count − pop < 2).
- On fetch_en:
  - push {pc, instruction}.
  - pc <= pc + 1, modulo 2^PC_W, so 16'hFFFF wraps to 0.
- Halt detection at capture:
  - If a captured instruction[8:4] == HALT_OP, set stop_fetch.
  - pc still increments past the halt address.
  - No further pushes occur.
- halted sets on the cycle after the halt entry is popped. It then holds until redirect or rst.
- Redirect (highest priority):
  - flush buffer (count <= 0);
  - pc <= redirect_pc;
  - clear stop_fetch and halted;
  - no fetch that cycle.
  - A pop coinciding with redirect still counts as accepted, because decode issued the redirect.
- Simultaneous push and pop with count==2: head advances and the new entry enters the tail; count stays 2.
- Simultaneous push and pop with count==1: count stays 1 and the new entry becomes head.
- No state changes when count==0 and no fetch is possible.
- States:
  - FETCH (stop_fetch=0)
  - DRAIN (stop_fetch=1, halted=0)
  - HALTED (halted=1)
- Transitions:
  - FETCH→DRAIN on halt capture.
  - DRAIN→HALTED on halt pop.
  - Any state→FETCH on redirect.
- `instruction` is sampled only when fetch_en=1. ROM contents are otherwise ignored.

## Timing
- Reset values (asynchronous, immediate):
  - pc=RESET_PC
  - count=0, so out_valid=0
  - out_inst=0, out_pc=0
  - halted=0, stop_fetch=0
- Fetch-to-out latency: an instruction at `pc` in cycle N is visible on out_* with out_valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held high; no bubbles.
- Redirect latency:
  - redirect asserted in cycle N → pc=redirect_pc in N+1;
  - out_valid=0 in N+1;
  - first redirected instruction valid in N+2.
- Backpressure: with out_ready low, the buffer fills in 2 cycles and pc then holds.
- out_inst and out_pc are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards buffer contents immediately. The first fetch is at RESET_PC on the first edge after rst deasserts.

## Test plan
- Reset, ROM pc1=9'h061, out_ready=1 → cycle 1 out_pc=1, out_inst=9'h061; pc increments every cycle; out_pc 1,2,3… on consecutive cycles.
- Default ROM (pc≥15 = 9'h1A0), ready=1 → pc15 delivered as 9'h1A0; pc stops at 16; no out_valid after it; halted=1 the following cycle and stays.
- ready=0 from reset for 5 cycles → count reaches 2; pc holds at 3; out_pc=1 stable; after ready=1, out_pc 1,2,3 on consecutive cycles with no gap.
- redirect=1, redirect_pc=10 while count=2 → next cycle out_valid=0, pc=10; cycle after, out_pc=10 with ROM data for 10 (9'h05x rsAdr).
- Redirect while halted (redirect_pc=5) → halted=0 next cycle; fetch resumes; out_pc=5 two cycles after redirect.
- redirect_pc=16'hFFFF with ready=1 → out_pc sequence FFFF, 0000, 0001; rst pulsed mid-stream drops out_valid immediately and fetch restarts at pc=1.
